// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus register map, transmit state encoding and
// the default oversample ratio used by the bit timers.
package spart_pkg;

    localparam logic [1:0] IOADDR_DATA    = 2'b00;
    localparam logic [1:0] IOADDR_STATUS  = 2'b01;
    localparam int         OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/spart_bit_timer.sv
// Counts brg_en oversample ticks and pulses bit_done on the tick that closes
// a bit time; clr holds the count at zero so the next bit starts fresh.
module spart_bit_timer
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic bit_done
);

    localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    assign bit_done = tick & (tick_cnt == LAST) & ~clr;

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte buffer feeding a shift register, serialised as
// 8N1 on txd. Define SPART_TX_PARITY_EN to insert an even-parity bit.
module spart_tx
    import spart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    input  logic [DATA_W-1:0] databus,
    input  logic              brg_en,
    output logic              tbr,
    output logic              txd
);

    localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state, state_d;
    logic              buf_full, buf_full_d;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BW-1:0]     bit_cnt, bit_cnt_d;
    logic              txd_d;
    logic              wr, accept, load;
    logic              timer_clr, bit_done;
`ifdef SPART_TX_PARITY_EN
    logic              parity_q;
`endif

    spart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .tick    (brg_en),
        .bit_done(bit_done)
    );

    // A write landing on the same cycle as a load refills the buffer
    assign wr         = iocs & ~iorw & (ioaddr == IOADDR_DATA);
    assign accept     = wr & (~buf_full | load);
    assign buf_full_d = accept | (buf_full & ~load);
    assign timer_clr  = (state == IDLE);

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        load      = 1'b0;
        txd_d     = 1'b1;

        case (state)
            IDLE: begin
                if (brg_en && buf_full) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_d   = shreg >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SPART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SPART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (buf_full) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shreg_d   = tx_buf;
            bit_cnt_d = '0;
        end

        // txd is registered from the next state so every edge lands on clk
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
`ifdef SPART_TX_PARITY_EN
            PARITY:  txd_d = parity_q;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else begin
            state    <= state_d;
            buf_full <= buf_full_d;
            bit_cnt  <= bit_cnt_d;
            txd      <= txd_d;
            tbr      <= ~buf_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_buf <= databus;
        end
        shreg <= shreg_d;
`ifdef SPART_TX_PARITY_EN
        if (load) begin
            parity_q <= ^tx_buf;
        end
`endif
    end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: brg_en every 4 clks (64-clk bits), frames
// checked cycle by cycle against hand-built bit patterns.
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       iocs    = 1'b0;
    logic       iorw    = 1'b1;
    logic [1:0] ioaddr  = 2'b00;
    logic [7:0] databus = 8'h00;
    logic       brg_en  = 1'b0;
    logic       tbr;
    logic       txd;

    int checks = 0;
    int errors = 0;
    bit brg_always = 1'b0;
    int div = 0;

    always #5 clk = ~clk;

    spart_tx #(
        .DATA_W    (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .brg_en (brg_en),
        .tbr    (tbr),
        .txd    (txd)
    );

    initial begin
        forever begin
            @(negedge clk);
            div    = (div + 1) % 4;
            brg_en = brg_always || (div == 0);
        end
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic rw, input logic [7:0] d);
        iocs    = 1'b1;
        iorw    = rw;
        ioaddr  = a;
        databus = d;
        @(negedge clk);
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
    endtask

    task automatic expect_idle(input string tag, input int n);
        logic stable;
        stable = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (txd !== 1'b1 || tbr !== 1'b1) stable = 1'b0;
            @(negedge clk);
        end
        check_bit(tag, stable, 1'b1);
    endtask

    // Checks every clk of a frame; optionally issues up to two bus writes
    // during the start bit (clk 0 and clk 4 of the bit).
    task automatic send_frame(input string tag, input logic [7:0] b, input bit wait_start,
                              input int bt, input int n_wr, input logic [7:0] wa,
                              input logic [7:0] wb);
        logic [NB-1:0] bits;
        logic          ok;
        int            t;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
`ifdef SPART_TX_PARITY_EN
        bits[9]    = ^b;
`endif
        bits[NB-1] = 1'b1;
        if (wait_start) begin
            t = 0;
            while (txd !== 1'b0 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            check_bit({tag, "_start_seen"}, txd, 1'b0);
            if (txd !== 1'b0) return;
        end
        check_bit({tag, "_tbr_after_load"}, tbr, 1'b1);
        for (int i = 0; i < NB; i++) begin
            ok = 1'b1;
            for (int k = 0; k < bt; k++) begin
                if (txd !== bits[i]) ok = 1'b0;
                if (i == 0) begin
                    if (n_wr >= 1 && k == 0) begin
                        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; databus = wa;
                    end
                    if (n_wr >= 2 && k == 4) begin
                        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; databus = wb;
                    end
                    if (k == 1 || k == 5) begin
                        iocs = 1'b0; iorw = 1'b1;
                    end
                end
                @(negedge clk);
            end
            check_bit($sformatf("%s_bit%0d", tag, i), ok, 1'b1);
        end
    endtask

    initial begin
        int t;

        // reset held 3 clks
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("rst_txd", txd, 1'b1);
            check_bit("rst_tbr", tbr, 1'b1);
        end
        rst = 1'b0;
        expect_idle("idle_after_rst", 1000);

        // single byte
        bus_write(2'b00, 1'b0, 8'hA5);
        check_bit("a5_tbr_low", tbr, 1'b0);
        send_frame("a5", 8'hA5, 1'b1, 64, 0, 8'h00, 8'h00);
        expect_idle("a5_idle_after", 200);

        // back-to-back frames
        bus_write(2'b00, 1'b0, 8'h3C);
        send_frame("b2b_3c", 8'h3C, 1'b1, 64, 1, 8'hC3, 8'h00);
        send_frame("b2b_c3", 8'hC3, 1'b0, 64, 0, 8'h00, 8'h00);
        expect_idle("b2b_idle_after", 200);

        // write while full is dropped
        bus_write(2'b00, 1'b0, 8'h11);
        send_frame("full_11", 8'h11, 1'b1, 64, 2, 8'h22, 8'h33);
        send_frame("full_22", 8'h22, 1'b0, 64, 0, 8'h00, 8'h00);
        expect_idle("full_no_33", 2000);

        // decode filtering
        bus_write(2'b00, 1'b1, 8'h5A);
        check_bit("dec_read_tbr", tbr, 1'b1);
        bus_write(2'b01, 1'b0, 8'h5A);
        check_bit("dec_a1_tbr", tbr, 1'b1);
        bus_write(2'b10, 1'b0, 8'h5A);
        check_bit("dec_a2_tbr", tbr, 1'b1);
        bus_write(2'b11, 1'b0, 8'h5A);
        check_bit("dec_a3_tbr", tbr, 1'b1);
        expect_idle("dec_no_frame", 700);

        // reset mid-frame with a byte waiting in the buffer
        bus_write(2'b00, 1'b0, 8'hFF);
        t = 0;
        while (txd !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check_bit("mid_start_seen", txd, 1'b0);
        repeat (64 * 4 + 10) @(negedge clk);
        bus_write(2'b00, 1'b0, 8'h55);
        check_bit("mid_buf_tbr_low", tbr, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_bit("mid_rst_txd", txd, 1'b1);
        check_bit("mid_rst_tbr", tbr, 1'b1);
        rst = 1'b0;
        expect_idle("mid_rst_idle", 700);
        bus_write(2'b00, 1'b0, 8'h07);
        send_frame("after_rst_07", 8'h07, 1'b1, 64, 0, 8'h00, 8'h00);
        expect_idle("after_rst_idle", 100);

        // brg_en held high: 16-clk bits
        brg_always = 1'b1;
        bus_write(2'b00, 1'b0, 8'h96);
        send_frame("cont_96", 8'h96, 1'b1, 16, 0, 8'h00, 8'h00);
        expect_idle("cont_idle_after", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
